// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake game datapath: default geometry of the
// playfield coordinates, body capacity, initial body length and the state
// encoding of the body-update FSM. Also imported by the head-position and
// render blocks so all agree on coordinate width and body size.
// -----------------------------------------------------------------------------
package snake_pkg;

   localparam int COORD_W_DEF  = 7;   // bits per x/y coordinate
   localparam int MAX_LEN_DEF  = 64;  // body buffer capacity, power of two
   localparam int INIT_LEN_DEF = 3;   // length reached by implicit growth

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,  // waiting for a step
      ST_SCAN   = 2'd1,  // comparing stored segments against the new head
      ST_UPDATE = 2'd2,  // writing the head, popping the tail
      ST_DEAD   = 2'd3   // self-collision seen, frozen until reset
   } snake_state_e;

endpackage

// File: rtl/snake_ring_ram.sv
// -----------------------------------------------------------------------------
// snake_ring_ram
// Body segment storage: DEPTH x DATA_W, one write port and one synchronous
// read port. Read data appears the cycle after the address is presented.
//
// Ports
//   clk_i    system clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data ({x, y})
//   raddr_i  read address, sampled every rising edge
//   rdata_o  registered read data
// -----------------------------------------------------------------------------
module snake_ring_ram
   import snake_pkg::*;
#(
   parameter  int DEPTH  = MAX_LEN_DEF,
   parameter  int DATA_W = 2 * COORD_W_DEF,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // NOTE: the array has no reset so it maps onto block RAM; stale contents
   // are harmless because only the first o_Length entries are ever compared.
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so a read of the address being written
      // returns the old word, matching the block RAM behaviour.
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/snake_body.sv
// -----------------------------------------------------------------------------
// snake_body
// Keeps the snake body as a circular buffer of {x, y} cells. Each accepted
// step scans the stored body (oldest to newest, one entry per cycle) for a
// self-collision, then appends the new head and, unless the snake is growing,
// pops the tail so the renderer can erase it.
//
// Ports
//   Clk                  system clock, rising edge
//   Rst                  synchronous active-high reset
//   i_Step               one-cycle pulse, new head coordinate valid
//   i_Head_x/i_Head_y    new head coordinate
//   i_Grow               food eaten this step, keep the tail
//   o_Busy               step in progress, i_Step ignored
//   o_Tail_Valid         one-cycle pulse, o_Tail_x/y is the cell to erase
//   o_Tail_x/o_Tail_y    popped tail coordinate
//   o_Length             number of stored segments
//   o_Full               o_Length == MAX_LEN
//   o_Hit                sticky self-collision flag
// -----------------------------------------------------------------------------
module snake_body
   import snake_pkg::*;
#(
   parameter  int COORD_W  = COORD_W_DEF,
   parameter  int MAX_LEN  = MAX_LEN_DEF,
   parameter  int INIT_LEN = INIT_LEN_DEF,
   localparam int PTR_W    = $clog2(MAX_LEN),
   localparam int LEN_W    = $clog2(MAX_LEN) + 1,
   localparam int CELL_W   = 2 * COORD_W
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               i_Step,
   input  logic [COORD_W-1:0] i_Head_x,
   input  logic [COORD_W-1:0] i_Head_y,
   input  logic               i_Grow,
   output logic               o_Busy,
   output logic               o_Tail_Valid,
   output logic [COORD_W-1:0] o_Tail_x,
   output logic [COORD_W-1:0] o_Tail_y,
   output logic [LEN_W-1:0]   o_Length,
   output logic               o_Full,
   output logic               o_Hit
);

   snake_state_e       state_q, state_d;
   logic [PTR_W-1:0]   head_ptr_q, head_ptr_d;
   logic [PTR_W-1:0]   tail_ptr_q, tail_ptr_d;
   logic [LEN_W-1:0]   length_q, length_d;
   logic [LEN_W-1:0]   scan_cnt_q, scan_cnt_d;   // offset from tail of entry under compare
   logic [CELL_W-1:0]  head_cell_q, head_cell_d; // latched new head
   logic               pop_q, pop_d;             // this step removes the tail
   logic               hit_q, hit_d;
   logic               tail_valid_q, tail_valid_d;
   logic [CELL_W-1:0]  tail_cell_q, tail_cell_d;

   logic               ram_we;
   logic [PTR_W-1:0]   ram_raddr;
   logic [CELL_W-1:0]  ram_rdata;

   logic               full;
   logic               scan_last;
   logic               cmp_en;
   logic               match;

   snake_ring_ram #(
      .DEPTH  (MAX_LEN),
      .DATA_W (CELL_W)
   ) u_ram (
      .clk_i   (Clk),
      .we_i    (ram_we),
      .waddr_i (head_ptr_q),
      .wdata_i (head_cell_q),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   assign full      = (length_q == LEN_W'(MAX_LEN));
   // An empty body still spends one cycle in SCAN.
   assign scan_last = (length_q == '0) || (scan_cnt_q == length_q - LEN_W'(1));
   // When the tail leaves this step the head may move into its cell.
   assign cmp_en    = (length_q != '0) && !(pop_q && (scan_cnt_q == '0));
   assign match     = cmp_en && (ram_rdata == head_cell_q);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q      <= ST_IDLE;
         head_ptr_q   <= '0;
         tail_ptr_q   <= '0;
         length_q     <= '0;
         scan_cnt_q   <= '0;
         head_cell_q  <= '0;
         pop_q        <= 1'b0;
         hit_q        <= 1'b0;
         tail_valid_q <= 1'b0;
         tail_cell_q  <= '0;
      end else begin
         state_q      <= state_d;
         head_ptr_q   <= head_ptr_d;
         tail_ptr_q   <= tail_ptr_d;
         length_q     <= length_d;
         scan_cnt_q   <= scan_cnt_d;
         head_cell_q  <= head_cell_d;
         pop_q        <= pop_d;
         hit_q        <= hit_d;
         tail_valid_q <= tail_valid_d;
         tail_cell_q  <= tail_cell_d;
      end
   end

   always_comb begin
      // NOTE: every signal gets its default before the case so no branch can
      // leave one unassigned and infer a latch.
      state_d      = state_q;
      head_ptr_d   = head_ptr_q;
      tail_ptr_d   = tail_ptr_q;
      length_d     = length_q;
      scan_cnt_d   = scan_cnt_q;
      head_cell_d  = head_cell_q;
      pop_d        = pop_q;
      hit_d        = hit_q;
      tail_valid_d = 1'b0;
      tail_cell_d  = tail_cell_q;
      ram_we       = 1'b0;
      ram_raddr    = tail_ptr_q;  // oldest entry is fetched while accepting a step

      case (state_q)
         ST_IDLE: begin
            if (i_Step && !hit_q) begin
               head_cell_d = {i_Head_x, i_Head_y};
               // Growing while full cannot add a segment, so it pops instead.
               pop_d       = i_Grow ? full
                                    : ((length_q >= LEN_W'(INIT_LEN)) && (length_q != '0));
               scan_cnt_d  = '0;
               state_d     = ST_SCAN;
            end
         end

         ST_SCAN: begin
            // Prefetch the next entry; on the last one re-fetch the tail so its
            // coordinate is on the read port during UPDATE.
            if (!scan_last) begin
               ram_raddr = tail_ptr_q + scan_cnt_q[PTR_W-1:0] + PTR_W'(1);
            end
            if (match) begin
               hit_d   = 1'b1;
               state_d = ST_DEAD;
            end else if (scan_last) begin
               state_d = ST_UPDATE;
            end else begin
               scan_cnt_d = scan_cnt_q + LEN_W'(1);
            end
         end

         ST_UPDATE: begin
            // When full, head and tail pointers coincide; the old tail is
            // already in the read register before this write lands.
            ram_we     = 1'b1;
            head_ptr_d = head_ptr_q + PTR_W'(1);
            if (pop_q) begin
               tail_valid_d = 1'b1;
               tail_cell_d  = ram_rdata;
               tail_ptr_d   = tail_ptr_q + PTR_W'(1);
            end else begin
               length_d = length_q + LEN_W'(1);
            end
            state_d = ST_IDLE;
         end

         ST_DEAD: begin
            // Frozen until reset.
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign o_Busy       = (state_q == ST_SCAN) || (state_q == ST_UPDATE);
   assign o_Tail_Valid = tail_valid_q;
   assign o_Tail_x     = tail_cell_q[CELL_W-1:COORD_W];
   assign o_Tail_y     = tail_cell_q[COORD_W-1:0];
   assign o_Length     = length_q;
   assign o_Full       = full;
   assign o_Hit        = hit_q;

endmodule

// File: tb/tb_snake_body.sv
// -----------------------------------------------------------------------------
// tb_snake_body
// Self-checking bench for snake_body with an 8-entry body. The reference model
// keeps the body as a queue of cells (oldest first) and applies the step rules
// directly: collision against every stored cell except a departing tail,
// append the head, pop the front unless growing.
// -----------------------------------------------------------------------------
module tb_snake_body;

   localparam int CW    = 7;
   localparam int MAXL  = 8;
   localparam int INITL = 3;
   localparam int LW    = $clog2(MAXL) + 1;

   typedef struct packed {
      logic [CW-1:0] x;
      logic [CW-1:0] y;
   } cell_t;

   logic          Clk;
   logic          Rst;
   logic          i_Step;
   logic [CW-1:0] i_Head_x;
   logic [CW-1:0] i_Head_y;
   logic          i_Grow;
   logic          o_Busy;
   logic          o_Tail_Valid;
   logic [CW-1:0] o_Tail_x;
   logic [CW-1:0] o_Tail_y;
   logic [LW-1:0] o_Length;
   logic          o_Full;
   logic          o_Hit;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   cell_t body_q[$];
   bit    m_hit;

   snake_body #(
      .COORD_W  (CW),
      .MAX_LEN  (MAXL),
      .INIT_LEN (INITL)
   ) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .i_Step       (i_Step),
      .i_Head_x     (i_Head_x),
      .i_Head_y     (i_Head_y),
      .i_Grow       (i_Grow),
      .o_Busy       (o_Busy),
      .o_Tail_Valid (o_Tail_Valid),
      .o_Tail_x     (o_Tail_x),
      .o_Tail_y     (o_Tail_y),
      .o_Length     (o_Length),
      .o_Full       (o_Full),
      .o_Hit        (o_Hit)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Apply one step to the model; returns whether a tail pops, which cell,
   // and the cycle count from the i_Step cycle to busy falling.
   function automatic void model_step(input cell_t h, input bit grow,
                                      output bit exp_pulse, output cell_t exp_tail,
                                      output int exp_lat);
      int n;
      bit pop;
      n         = body_q.size();
      exp_pulse = 1'b0;
      exp_tail  = '0;
      exp_lat   = ((n == 0) ? 1 : n) + 2;
      if (m_hit) return;
      pop = grow ? (n == MAXL) : (n >= INITL && n > 0);
      for (int i = 0; i < n; i++) begin
         if (!(pop && i == 0) && body_q[i] == h) begin
            m_hit = 1'b1;
            return;
         end
      end
      body_q.push_back(h);
      if (pop) begin
         exp_tail  = body_q.pop_front();
         exp_pulse = 1'b1;
      end
   endfunction

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic do_reset();
      i_Step   = 1'b0;
      i_Grow   = 1'b0;
      i_Head_x = '0;
      i_Head_y = '0;
      Rst      = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      Rst = 1'b0;
      body_q.delete();
      m_hit = 1'b0;
   endtask

   // Pulse i_Step, follow the step until busy falls (bounded), plus one cycle
   // more so a repeated tail pulse would be counted.
   task automatic do_step(input cell_t h, input bit grow,
                          output int lat, output int pulses, output cell_t tail);
      i_Head_x = h.x;
      i_Head_y = h.y;
      i_Grow   = grow;
      i_Step   = 1'b1;
      @(posedge Clk);
      #1;
      i_Step = 1'b0;
      i_Grow = 1'b0;
      lat    = 1;
      pulses = 0;
      tail   = '0;
      while (o_Busy && lat < 200) begin
         @(posedge Clk);
         #1;
         lat++;
         if (o_Tail_Valid) begin
            pulses++;
            tail = {o_Tail_x, o_Tail_y};
         end
      end
      @(posedge Clk);
      #1;
      if (o_Tail_Valid) pulses++;
   endtask

   // Body (1,1),(2,1),(2,2),(1,2), oldest first.
   task automatic build_square();
      cell_t h;
      bit    ep;
      cell_t et;
      int    el, lat, pulses;
      cell_t tail;
      do_reset();
      h = {7'd1, 7'd1}; model_step(h, 1'b0, ep, et, el); do_step(h, 1'b0, lat, pulses, tail);
      h = {7'd2, 7'd1}; model_step(h, 1'b0, ep, et, el); do_step(h, 1'b0, lat, pulses, tail);
      h = {7'd2, 7'd2}; model_step(h, 1'b0, ep, et, el); do_step(h, 1'b0, lat, pulses, tail);
      h = {7'd1, 7'd2}; model_step(h, 1'b1, ep, et, el); do_step(h, 1'b1, lat, pulses, tail);
      checks++;
      if (o_Length !== LW'(4)) begin
         failures++;
         $display("FAIL square_len: got %0d expected 4", o_Length);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({o_Busy, o_Tail_Valid, o_Full, o_Hit} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: got busy=%b tv=%b full=%b hit=%b expected all 0",
                  o_Busy, o_Tail_Valid, o_Full, o_Hit);
      end
      checks++;
      if (o_Length !== '0 || o_Tail_x !== '0 || o_Tail_y !== '0) begin
         failures++;
         $display("FAIL reset_values: got len=%0d tail=(%0d,%0d) expected 0,(0,0)",
                  o_Length, o_Tail_x, o_Tail_y);
      end
   endtask

   // Three implicit-growth steps, then the first pop of (5,5).
   task automatic test_basic();
      cell_t h, et, tail;
      bit    ep;
      int    el, lat, pulses;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         h.x = CW'(5 + i);
         h.y = 7'd5;
         model_step(h, 1'b0, ep, et, el);
         do_step(h, 1'b0, lat, pulses, tail);
         checks++;
         if (pulses != ((i == 3) ? 1 : 0)) begin
            failures++;
            $display("FAIL basic_pulse[%0d]: got %0d pulses expected %0d", i, pulses, (i == 3) ? 1 : 0);
         end
         checks++;
         if (o_Length !== LW'((i == 3) ? 3 : i + 1)) begin
            failures++;
            $display("FAIL basic_len[%0d]: got %0d expected %0d", i, o_Length, (i == 3) ? 3 : i + 1);
         end
         checks++;
         if (lat != el) begin
            failures++;
            $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, lat, el);
         end
      end
      checks++;
      if (tail !== {7'd5, 7'd5} || lat != 5) begin
         failures++;
         $display("FAIL basic_first_pop: got (%0d,%0d) lat %0d expected (5,5) lat 5",
                  tail.x, tail.y, lat);
      end
   endtask

   // Continues from test_basic: grow at length 3, then a step with an extra
   // i_Step issued while busy.
   task automatic test_grow_and_ignore();
      cell_t h, et, tail;
      bit    ep;
      int    el, lat, pulses, busy_seen;
      h = {7'd9, 7'd5};
      model_step(h, 1'b1, ep, et, el);
      do_step(h, 1'b1, lat, pulses, tail);
      checks++;
      if (pulses != 0 || o_Length !== LW'(4)) begin
         failures++;
         $display("FAIL grow_step: got pulses=%0d len=%0d expected 0, 4", pulses, o_Length);
      end
      h = {7'd10, 7'd5};
      model_step(h, 1'b0, ep, et, el);
      i_Head_x = h.x; i_Head_y = h.y; i_Step = 1'b1;
      @(posedge Clk); #1;
      i_Step = 1'b0;
      checks++;
      if (o_Busy !== 1'b1) begin
         failures++;
         $display("FAIL ignore_busy: got busy=%b expected 1", o_Busy);
      end
      i_Head_x = 7'd20; i_Head_y = 7'd20; i_Grow = 1'b1; i_Step = 1'b1;
      @(posedge Clk); #1;
      i_Step = 1'b0; i_Grow = 1'b0;
      pulses = 0;
      lat    = 0;
      while (o_Busy && lat < 200) begin
         @(posedge Clk); #1;
         lat++;
         if (o_Tail_Valid) begin
            pulses++;
            tail = {o_Tail_x, o_Tail_y};
         end
      end
      busy_seen = 0;
      repeat (6) begin
         @(posedge Clk); #1;
         if (o_Busy || o_Tail_Valid) busy_seen++;
      end
      checks++;
      if (busy_seen != 0) begin
         failures++;
         $display("FAIL ignore_no_queue: got %0d busy cycles expected 0", busy_seen);
      end
      checks++;
      if (pulses != 1 || tail !== et || o_Length !== LW'(body_q.size())) begin
         failures++;
         $display("FAIL ignore_result: got pulses=%0d tail=(%0d,%0d) len=%0d expected 1,(%0d,%0d),%0d",
                  pulses, tail.x, tail.y, o_Length, et.x, et.y, body_q.size());
      end
   endtask

   task automatic test_tail_exclusion();
      cell_t h, et, tail;
      bit    ep;
      int    el, lat, pulses, busy_seen;
      build_square();
      h = {7'd1, 7'd1};
      model_step(h, 1'b0, ep, et, el);
      do_step(h, 1'b0, lat, pulses, tail);
      checks++;
      if (o_Hit !== 1'b0 || pulses != 1 || tail !== {7'd1, 7'd1} || o_Length !== LW'(4)) begin
         failures++;
         $display("FAIL tail_excluded: got hit=%b pulses=%0d tail=(%0d,%0d) len=%0d expected 0,1,(1,1),4",
                  o_Hit, pulses, tail.x, tail.y, o_Length);
      end
      build_square();
      model_step(h, 1'b1, ep, et, el);
      do_step(h, 1'b1, lat, pulses, tail);
      checks++;
      if (o_Hit !== 1'b1 || pulses != 0 || o_Busy !== 1'b0 || o_Length !== LW'(4)) begin
         failures++;
         $display("FAIL grow_hit: got hit=%b pulses=%0d busy=%b len=%0d expected 1,0,0,4",
                  o_Hit, pulses, o_Busy, o_Length);
      end
      i_Head_x = 7'd50; i_Head_y = 7'd50; i_Step = 1'b1;
      @(posedge Clk); #1;
      i_Step = 1'b0;
      busy_seen = 0;
      repeat (8) begin
         if (o_Busy || o_Tail_Valid) busy_seen++;
         @(posedge Clk); #1;
      end
      checks++;
      if (busy_seen != 0 || o_Hit !== 1'b1 || o_Length !== LW'(4)) begin
         failures++;
         $display("FAIL dead_ignores: got busy_cycles=%0d hit=%b len=%0d expected 0,1,4",
                  busy_seen, o_Hit, o_Length);
      end
   endtask

   task automatic test_full_wrap();
      cell_t h, et, tail;
      bit    ep, grow;
      int    el, lat, pulses;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         h.x = CW'(10 + i);
         h.y = 7'd30;
         if (i == 7) begin
            checks++;
            if (o_Full !== 1'b0 || o_Length !== LW'(7)) begin
               failures++;
               $display("FAIL not_full_at_7: got full=%b len=%0d expected 0,7", o_Full, o_Length);
            end
         end
         model_step(h, 1'b1, ep, et, el);
         do_step(h, 1'b1, lat, pulses, tail);
      end
      checks++;
      if (o_Full !== 1'b1 || o_Length !== LW'(8)) begin
         failures++;
         $display("FAIL full_at_8: got full=%b len=%0d expected 1,8", o_Full, o_Length);
      end
      for (int i = 8; i < 28; i++) begin
         h.x  = CW'(10 + i);
         h.y  = 7'd30;
         grow = 1'($urandom_range(0, 1));
         model_step(h, grow, ep, et, el);
         do_step(h, grow, lat, pulses, tail);
         checks++;
         if (pulses != 1 || tail !== et || o_Length !== LW'(8) || o_Full !== 1'b1 || lat != el) begin
            failures++;
            $display("FAIL wrap_step[%0d]: got pulses=%0d tail=(%0d,%0d) len=%0d full=%b lat=%0d expected 1,(%0d,%0d),8,1,%0d",
                     i, pulses, tail.x, tail.y, o_Length, o_Full, lat, et.x, et.y, el);
         end
      end
   endtask

   task automatic test_reset_mid_scan();
      cell_t h, et, tail;
      bit    ep;
      int    el, lat, pulses;
      build_square();
      h = {7'd3, 7'd1};
      model_step(h, 1'b0, ep, et, el);
      do_step(h, 1'b0, lat, pulses, tail);  // pops (1,1), tail outputs non-zero
      i_Head_x = 7'd9; i_Head_y = 7'd9; i_Step = 1'b1;
      @(posedge Clk); #1;
      i_Step = 1'b0;
      @(posedge Clk); #1;
      checks++;
      if (o_Busy !== 1'b1) begin
         failures++;
         $display("FAIL midscan_busy: got busy=%b expected 1", o_Busy);
      end
      Rst = 1'b1;
      @(posedge Clk); #1;
      Rst = 1'b0;
      body_q.delete();
      m_hit = 1'b0;
      checks++;
      if ({o_Busy, o_Tail_Valid, o_Full, o_Hit} !== 4'b0000 || o_Length !== '0 ||
          o_Tail_x !== '0 || o_Tail_y !== '0) begin
         failures++;
         $display("FAIL midscan_reset: got busy=%b tv=%b full=%b hit=%b len=%0d tail=(%0d,%0d) expected all 0",
                  o_Busy, o_Tail_Valid, o_Full, o_Hit, o_Length, o_Tail_x, o_Tail_y);
      end
      h = {7'd3, 7'd3};
      model_step(h, 1'b0, ep, et, el);
      do_step(h, 1'b0, lat, pulses, tail);
      checks++;
      if (lat != 3 || pulses != 0 || o_Length !== LW'(1)) begin
         failures++;
         $display("FAIL after_reset_step: got lat=%0d pulses=%0d len=%0d expected 3,0,1",
                  lat, pulses, o_Length);
      end
   endtask

   // Small 4x4 field so collisions happen often; reset after each hit.
   task automatic test_random();
      cell_t h, et, tail;
      bit    ep, grow;
      int    el, lat, pulses;
      do_reset();
      for (int i = 0; i < 150; i++) begin
         h.x  = CW'($urandom_range(0, 3));
         h.y  = CW'($urandom_range(0, 3));
         grow = ($urandom_range(0, 3) == 0);
         model_step(h, grow, ep, et, el);
         do_step(h, grow, lat, pulses, tail);
         checks++;
         if (pulses != int'(ep) || (ep && tail !== et)) begin
            failures++;
            $display("FAIL rand_tail[%0d]: got pulses=%0d tail=(%0d,%0d) expected %0d,(%0d,%0d)",
                     i, pulses, tail.x, tail.y, ep, et.x, et.y);
         end
         checks++;
         if (o_Length !== LW'(body_q.size()) || o_Hit !== m_hit || o_Busy !== 1'b0 ||
             o_Full !== (body_q.size() == MAXL)) begin
            failures++;
            $display("FAIL rand_state[%0d]: got len=%0d hit=%b busy=%b full=%b expected %0d,%b,0,%b",
                     i, o_Length, o_Hit, o_Busy, o_Full, body_q.size(), m_hit, body_q.size() == MAXL);
         end
         if (!m_hit) begin
            checks++;
            if (lat != el) begin
               failures++;
               $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, el);
            end
         end else begin
            do_reset();
         end
      end
   endtask

   initial begin
      Rst      = 1'b1;
      i_Step   = 1'b0;
      i_Grow   = 1'b0;
      i_Head_x = '0;
      i_Head_y = '0;
      @(posedge Clk); #1;
      test_reset();
      test_basic();
      test_grow_and_ignore();
      test_tail_exclusion();
      test_full_wrap();
      test_reset_mid_scan();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/snake_body.md
SNAKE_BODY -- requirements
Module: snake_body

Interface
REQ-001 Parameter COORD_W, default 7, width of each head/tail coordinate.
REQ-002 Parameter MAX_LEN, default 64, segment capacity of the body buffer (power of two).
REQ-003 Parameter INIT_LEN, default 3, length reached by implicit growth after reset.
REQ-004 Clk  input  1  single system clock; all logic on rising edge.
REQ-005 Rst  input  1  reset, synchronous, active-high.
REQ-006 i_Step  input  1  one-cycle pulse: new head coordinate valid from the head-position block.
REQ-007 i_Head_x, i_Head_y  input  COORD_W each  new head coordinate, sampled when i_Step=1.
REQ-008 i_Grow  input  1  food eaten; sampled with i_Step; tail is kept this step.
REQ-009 o_Busy  output  1  step in progress; i_Step ignored while high.
REQ-010 o_Tail_Valid  output  1  one-cycle pulse: o_Tail_x/o_Tail_y hold the popped tail cell for erase.
REQ-011 o_Tail_x, o_Tail_y  output  COORD_W each  popped tail coordinate, valid only with o_Tail_Valid.
REQ-012 o_Length  output  $clog2(MAX_LEN)+1  current number of stored segments.
REQ-013 o_Full  output  1  o_Length == MAX_LEN.
REQ-014 o_Hit  output  1  sticky self-collision flag.

Function
REQ-015 Body SHALL be a circular buffer of MAX_LEN entries with head and tail pointers wrapping modulo MAX_LEN.
REQ-016 FSM states SHALL be IDLE, SCAN, UPDATE, DEAD.
REQ-017 IDLE: on i_Step=1 and o_Hit=0, latch head coordinate and i_Grow, set scan index to tail, go to SCAN; o_Busy=1 from next cycle.
REQ-018 SCAN: compare one stored entry per cycle against latched head, oldest to newest; go to UPDATE after last entry or immediately if o_Length=0.
REQ-019 Effective pop = NOT grow AND o_Length >= INIT_LEN AND NOT full-override; grow while o_Full=1 SHALL be treated as pop (length saturates at MAX_LEN).
REQ-020 The tail entry SHALL be excluded from the comparison when effective pop=1 (head may move into vacated tail cell).
REQ-021 Any match SHALL set o_Hit and go to DEAD with no buffer write and no tail pop.
REQ-022 UPDATE (no match): write head at head pointer, advance head pointer; if pop, read tail, pulse o_Tail_Valid with its coordinate, advance tail pointer; else increment o_Length; return to IDLE.
REQ-023 Step latency SHALL be o_Length+2 cycles from i_Step to o_Tail_Valid/o_Busy falling (1 cycle SCAN minimum when empty).
REQ-024 i_Step while o_Busy=1 or in DEAD SHALL be ignored entirely (no queuing).
REQ-025 DEAD SHALL hold o_Busy=0, o_Hit=1 and all buffer state until Rst.
REQ-026 o_Tail_Valid SHALL never be high for two consecutive cycles.

Reset
REQ-027 Rst=1 at a rising edge SHALL force IDLE, pointers=0, o_Length=0, o_Busy=0, o_Tail_Valid=0, o_Tail_x/y=0, o_Hit=0, o_Full=0, regardless of current state (mid-SCAN aborts without write).
REQ-028 Buffer memory contents need not be cleared; entries beyond o_Length are never compared.

Structure
REQ-029 Shared package snake_pkg SHALL hold COORD_W, MAX_LEN, INIT_LEN defaults and the FSM state encoding, shared with the head-position and render blocks.
REQ-030 Storage SHALL be a sub-module snake_ring_ram (1 write port, 1 synchronous read port, MAX_LEN x 2*COORD_W); FSM and pointers stay in snake_body.

Verification
REQ-031 Reset then steps (5,5),(6,5),(7,5) no grow -> o_Length=1,2,3, no o_Tail_Valid.
REQ-032 Fourth step (8,5) no grow -> o_Tail_Valid pulse with (5,5), o_Length stays 3, latency 5 cycles.
REQ-033 Step with i_Grow=1 at length 3 -> no tail pulse, o_Length=4; i_Step pulsed while o_Busy=1 -> ignored, length unchanged.
REQ-034 Body (1,1),(2,1),(2,2),(1,2) length 4, step to (1,1) no grow -> no hit (tail excluded), tail (1,1) popped; same with grow -> o_Hit=1, DEAD, later steps ignored.
REQ-035 MAX_LEN=8: grow to 8 -> o_Full=1; further grow step pops tail, length stays 8; pointers wrap past index 7 correctly over 20 steps.
REQ-036 Rst asserted mid-SCAN -> next cycle all outputs at reset values, subsequent step starts from length 0.
